// File: rtl/dcb_pkg.sv
// Shared types and constants for the down counter bank.
package dcb_pkg;

  typedef enum logic [1:0] {
    ARMED    = 2'd0,
    COUNTING = 2'd1,
    DONE     = 2'd2
  } dcb_state_t;

  localparam logic DCB_ONE_SHOT    = 1'b0;
  localparam logic DCB_AUTO_RELOAD = 1'b1;

endpackage

// File: rtl/dcb_channel.sv
// One down-counter channel: counter, ARMED/COUNTING/DONE state machine and reload register.
// Auto-reload (and the reload register) exist only when DCB_AUTO_RELOAD_EN is defined.
module dcb_channel
  import dcb_pkg::*;
#(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [N-1:0] load_value,
  input  logic         enable,
  input  logic         mode,
  output logic [N-1:0] count,
  output logic         active,
  output logic         done
);

  dcb_state_t   state_q, state_d;
  logic [N-1:0] count_q, count_d;
  logic         done_q, done_d;
  logic         reload_en;
  logic [N-1:0] reload_val;

`ifdef DCB_AUTO_RELOAD_EN
  logic [N-1:0] reload_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      reload_q <= '1;
    end else if (load) begin
      reload_q <= load_value;
    end
  end

  assign reload_val = reload_q;
  assign reload_en  = (mode == DCB_AUTO_RELOAD);
`else
  logic unused_mode;

  assign unused_mode = mode;
  assign reload_val  = '1;
  assign reload_en   = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ARMED;
      count_q <= '1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      done_q  <= done_d;
    end
  end

  // A channel at zero is always in DONE, so the decrement path never wraps.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    done_d  = 1'b0;
    if (load) begin
      count_d = load_value;
      state_d = (load_value != '0) ? ARMED : DONE;
    end else if (enable && (state_q != DONE)) begin
      if (count_q > N'(1)) begin
        count_d = count_q - N'(1);
        state_d = COUNTING;
      end else begin
        done_d = 1'b1;
        if (reload_en) begin
          count_d = reload_val;
          state_d = COUNTING;
        end else begin
          count_d = '0;
          state_d = DONE;
        end
      end
    end
  end

  always_comb begin
    active = (state_q == COUNTING);
  end

  assign count = count_q;
  assign done  = done_q;

endmodule

// File: rtl/down_counter_bank.sv
// Bank of CHANNELS independent down counters with a combined activity flag.
// Optional auto-reload per channel is compiled in with DCB_AUTO_RELOAD_EN.
module down_counter_bank
  import dcb_pkg::*;
#(
  parameter int N        = 8,
  parameter int CHANNELS = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [CHANNELS-1:0]   load,
  input  logic [CHANNELS*N-1:0] load_value,
  input  logic [CHANNELS-1:0]   enable,
  input  logic [CHANNELS-1:0]   mode,
  output logic [CHANNELS*N-1:0] count,
  output logic [CHANNELS-1:0]   active,
  output logic [CHANNELS-1:0]   done,
  output logic                  any_active
);

  generate
    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
      dcb_channel #(
        .N(N)
      ) u_ch (
        .clk        (clk),
        .reset      (reset),
        .load       (load[gi]),
        .load_value (load_value[gi*N +: N]),
        .enable     (enable[gi]),
        .mode       (mode[gi]),
        .count      (count[gi*N +: N]),
        .active     (active[gi]),
        .done       (done[gi])
      );
    end
  endgenerate

  assign any_active = |active;

endmodule
